// File: rtl/mpsoc_uart_pkg.sv
// Shared definitions for the board console multiplexer: UART frame length,
// mux FSM encoding and the clock-to-baud divider helper.
package mpsoc_uart_pkg;

  // start + 8 data + stop
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    MUX_RUN,
    MUX_WAIT_IDLE,
    MUX_GUARD
  } mux_st_t;

  // Clock cycles per UART bit (integer division).
  function automatic int unsigned bit_cycles(input int unsigned clk_hz,
                                             input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_frame_tracker.sv
// Per-line UART character tracker. A falling start edge starts a frame;
// the tracker stays busy until the middle of the stop bit, ignoring the
// line level inside the frame, so a switch never lands mid-character.
module uart_frame_tracker #(
  parameter int unsigned BIT_CYCLES = 10
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic line_i,
  output logic idle_o
);
  import mpsoc_uart_pkg::*;

  // Mid-stop-bit point measured from the start-bit detection.
  localparam int unsigned FRAME_CYCLES = (FRAME_BITS - 1) * BIT_CYCLES + BIT_CYCLES / 2;
  localparam int unsigned CW = $clog2(FRAME_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: start on a low line, count out one frame, then re-arm.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (!busy_q) begin
      if (!line_i) begin
        busy_d = 1'b1;
        cnt_d  = '0;
      end
    end else if (cnt_q == CNT_LAST) begin
      busy_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Tracker state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign idle_o = ~busy_q;

endmodule

// File: rtl/uart_console_mux.sv
// Board console multiplexer: routes one board UART and bootloader strap to
// one of NUM_TILES tiles. Switches only between characters and forces an
// idle guard interval on the board TX line while changing channel.
// Optional macro RX_BROADCAST_EN: board RX is fanned out to every tile.
module uart_console_mux #(
  parameter int unsigned NUM_TILES  = 9,
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEF_SEL    = 0,
  parameter int unsigned GUARD_BITS = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [$clog2(NUM_TILES)-1:0] sel_i,
  input  logic [NUM_TILES-1:0]         uart_tx_i,
  output logic                         uart_tx_o,
  input  logic                         uart_rx_i,
  output logic [NUM_TILES-1:0]         uart_rx_o,
  input  logic                         bootloader_i,
  output logic [NUM_TILES-1:0]         bootloader_o,
  output logic [$clog2(NUM_TILES)-1:0] sel_active_o,
  output logic                         switch_pending_o,
  output logic                         sel_err_o
);
  import mpsoc_uart_pkg::*;

  localparam int unsigned SW           = $clog2(NUM_TILES);
  localparam int unsigned BIT_CYC      = bit_cycles(CLK_HZ, BAUD);
  localparam int unsigned GUARD_CYCLES = GUARD_BITS * BIT_CYC;
  localparam int unsigned GW           = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [SW-1:0] SEL_DEF    = SW'(DEF_SEL);
  localparam logic [SW:0]   SEL_LIMIT  = (SW + 1)'(NUM_TILES);

  logic [SW-1:0]        sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic                 boot_s1_q, boot_s1_d, boot_s2_q, boot_s2_d;
  mux_st_t              state_q, state_d;
  logic [SW-1:0]        active_q, active_d, cand_q, cand_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic                 tx_q, tx_d;
  logic                 pend_q, pend_d;
  logic                 err_q, err_d;
  logic [NUM_TILES-1:0] boot_q, boot_d;
  logic [NUM_TILES-1:0] rx_q, rx_d;
  logic [NUM_TILES-1:0] trk_idle;
  logic                 sel_valid;

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_trk
    uart_frame_tracker #(.BIT_CYCLES(BIT_CYC)) u_trk (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .line_i (uart_tx_i[i]),
      .idle_o (trk_idle[i])
    );
  end

  // Two-flop synchronisers for the asynchronous level inputs.
  always_comb begin
    sel_s1_d  = sel_i;
    sel_s2_d  = sel_s1_q;
    rx_s1_d   = uart_rx_i;
    rx_s2_d   = rx_s1_q;
    boot_s1_d = bootloader_i;
    boot_s2_d = boot_s1_q;
  end

  // Mux FSM: run, wait for the active character to finish, guard, hand over.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    cand_d    = cand_q;
    guard_d   = guard_q;
    tx_d      = uart_tx_i[active_q];
    sel_valid = ({1'b0, sel_s2_q} < SEL_LIMIT);
    unique case (state_q)
      MUX_RUN: begin
        if (sel_valid && (sel_s2_q != active_q)) begin
          cand_d  = sel_s2_q;
          state_d = MUX_WAIT_IDLE;
        end
      end
      MUX_WAIT_IDLE: begin
        if (sel_s2_q == active_q) begin
          state_d = MUX_RUN;
        end else begin
          if (sel_valid) cand_d = sel_s2_q;
          if (trk_idle[active_q]) begin
            state_d = MUX_GUARD;
            guard_d = '0;
          end
        end
      end
      MUX_GUARD: begin
        tx_d = 1'b1;
        if (sel_valid) cand_d = sel_s2_q;
        // Guard length is a minimum: hand over only once the new channel
        // is between characters, so the host never sees a partial frame.
        if (guard_q != GUARD_LAST) begin
          guard_d = guard_q + 1'b1;
        end else if (trk_idle[cand_q]) begin
          active_d = cand_q;
          state_d  = MUX_RUN;
        end
      end
      default: state_d = MUX_RUN;
    endcase
  end

  // Registered side outputs, decoded from next state so they align with it.
  always_comb begin
    err_d  = err_q | ~sel_valid;
    pend_d = (state_d != MUX_RUN);
    boot_d = '0;
    if (boot_s2_q && (state_d == MUX_RUN)) boot_d[active_d] = 1'b1;
`ifdef RX_BROADCAST_EN
    rx_d = {NUM_TILES{rx_s2_q}};
`else
    rx_d = '1;
    if (state_d != MUX_GUARD) rx_d[active_d] = rx_s2_q;
`endif
  end

  // State and output registers; reset returns every line to idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_s1_q  <= SEL_DEF;
      sel_s2_q  <= SEL_DEF;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      boot_s1_q <= 1'b0;
      boot_s2_q <= 1'b0;
      state_q   <= MUX_RUN;
      active_q  <= SEL_DEF;
      cand_q    <= SEL_DEF;
      guard_q   <= '0;
      tx_q      <= 1'b1;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      boot_q    <= '0;
      rx_q      <= '1;
    end else begin
      sel_s1_q  <= sel_s1_d;
      sel_s2_q  <= sel_s2_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      boot_s1_q <= boot_s1_d;
      boot_s2_q <= boot_s2_d;
      state_q   <= state_d;
      active_q  <= active_d;
      cand_q    <= cand_d;
      guard_q   <= guard_d;
      tx_q      <= tx_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      boot_q    <= boot_d;
      rx_q      <= rx_d;
    end
  end

  assign uart_tx_o        = tx_q;
  assign uart_rx_o        = rx_q;
  assign bootloader_o     = boot_q;
  assign sel_active_o     = active_q;
  assign switch_pending_o = pend_q;
  assign sel_err_o        = err_q;

endmodule
